lsu_store_buffer: RTL and testbench
===================================

Name: lsu_store_buffer

Overview:
Parametrised store buffer sitting between execute_lsu and the data bus. It accepts speculative stores tagged with ROB id and holds them in a circular FIFO. Entries are marked committed as the ROB retires them and drained in order to the bus. Uncommitted entries are discarded on pipeline flush, and the buffer forwards byte-granular store data to in-flight loads.

Parameters:
DEPTH, 16, number of entries; power of two, ≥2
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, bus data width; 32 or 64
ROB_ID_WIDTH, 7, ROB id width
SIZE_WIDTH, 2, size code width (00 byte, 01 half, 10 word, 11 dword when DATA_WIDTH=64)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
push  in  1  store enqueue request
push_rob_id  in  ROB_ID_WIDTH  ROB id of store
push_addr  in  ADDR_WIDTH  byte address
push_size  in  SIZE_WIDTH  size code
push_data  in  DATA_WIDTH  store data, LSB-aligned
full  out  1  no free entry
empty  out  1  no valid entry
commit_valid  in  1  ROB retires commit_rob_id this cycle
commit_rob_id  in  ROB_ID_WIDTH  retired ROB id
flush  in  1  discard all uncommitted entries
ld_addr  in  ADDR_WIDTH  load query address
ld_size  in  SIZE_WIDTH  load query size
fwd_data  out  DATA_WIDTH  forwarded bytes, lane-aligned (lane = addr mod DATA_WIDTH/8)
fwd_mask  out  DATA_WIDTH/8  lanes supplied by buffer
bus_req  out  1  head entry ready to write
bus_addr  out  ADDR_WIDTH  head address with lane bits zeroed
bus_data  out  DATA_WIDTH  head data, lane-aligned
bus_wmask  out  DATA_WIDTH/8  head byte enables
bus_ready  in  1  bus accepts write this cycle

Behaviour:
- Storage: circular array; head/tail pointers carry an extra wrap bit. count = tail − head. full = (count==DEPTH); empty = (count==0). Both combinational from registers.
- Entry fields: valid, committed, rob_id, line address, wmask, lane-aligned data.
- Encoding at push: byte offset off = push_addr[log2(DATA_WIDTH/8)-1:0]; mask = ((1<<(1<<size))−1)<<off; data = push_data<<(8·off). Mask bits beyond the lane width are truncated; no misalignment check is done here (upstream raises the exception).
- Push: when push && !full && !flush, write at tail; tail+1 at the edge. A push while full is ignored; the upstream must hold it (execute_lsu stalls fifo pop on full).
- Commit: when commit_valid, every valid entry with rob_id==commit_rob_id and committed==0 sets committed at the edge. The match runs against the pre-edge contents, so a store pushed in the same cycle is not committed. Commits arrive in program order, so committed entries always form a prefix from head.
- Flush: at the edge, tail ← head + (number of committed entries, including any committed this cycle). Valid bits of the discarded entries are cleared. A push in the same cycle is dropped.
- Drain: bus_req = !empty && head.committed. bus_addr, bus_data and bus_wmask are driven combinationally from head. When bus_req && bus_ready, head+1 and the head valid bit clears at the edge. Drain proceeds during flush; a flush never cancels a committed write.
- Simultaneous pop and push while full: full is evaluated before the edge, so the push is refused.
- Forwarding (combinational): for each valid entry, committed or not, with line address == ld_addr line, the entry contributes entry.wmask & load mask. Scan order is head→tail and the youngest writer wins per byte. fwd_mask is the OR of contributions; bytes with fwd_mask=0 drive 0. Partial coverage is legal; the consumer merges with bus data.
- Pointer wrap: indices use the low log2(DEPTH) bits; full/empty use the wrap bit.
- Reset (rst==0 at clk edge): head=tail=0, all valid/committed cleared. Outputs become full=0, empty=1, bus_req=0, bus_wmask=0, fwd_mask=0, fwd_data=0. Reset overrides push/commit/flush in the same cycle, and a reset mid-drain abandons the head write.

Test Plan:
- Reset then push sh rob 7 addr 0xaaccbeef data 0xdeadbeef (32-bit) -> next cycle empty=0, bus_req=0; commit rob 7 -> bus_req=1, bus_addr=0xaaccbeec, bus_wmask=4'b1000 truncated, bus_data[31:24]=0xef; bus_ready=1 -> empty=1.
- Push 16 stores, 17th push asserted -> full=1 after 16, 17th ignored, count stays 16; one drain + push same cycle -> push refused.
- Push rob 1,2,3; commit 1; flush -> only rob 1 remains; tail=head+1; subsequent push lands at index 1.
- Forward: push sw 0x11223344 @0x100 then sb 0xaa @0x101; ld_addr 0x100 size 10 -> fwd_mask=4'b1111, fwd_data=0x1122aa44.
- Partial forward: push sh 0xbeef @0x202; ld word @0x200 -> fwd_mask=4'b1100, fwd_data=0xbeef0000.
- Wrap: 40 push/commit/drain cycles with DEPTH=4 -> writes drain in push order and bus_wmask matches each size; rst=0 mid-sequence -> empty=1, bus_req=0 next cycle.

Source files
------------

// File: rtl/lsu_store_buffer.sv
// Purpose: in-order store buffer; holds speculative stores until ROB commit, drains them to the bus, forwards bytes to loads.
// Latency: push visible (empty/forwarding) one cycle after accept; committed head presents bus_req one cycle after commit.
// Backpressure: full refuses pushes (upstream holds); bus_ready=0 holds the head write in place.
//
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   push/push_rob_id/addr/size/data store enqueue; full/empty status
//   commit_valid/commit_rob_id     ROB retirement marks matching entry committed
//   flush                          discard all uncommitted entries
//   ld_addr/ld_size -> fwd_data/fwd_mask   combinational byte forwarding
//   bus_req/addr/data/wmask, bus_ready      head write to the data bus
module lsu_store_buffer #(
  parameter int DEPTH        = 16,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int ROB_ID_WIDTH = 7,
  parameter int SIZE_WIDTH   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [ROB_ID_WIDTH-1:0] push_rob_id,
  input  logic [ADDR_WIDTH-1:0]   push_addr,
  input  logic [SIZE_WIDTH-1:0]   push_size,
  input  logic [DATA_WIDTH-1:0]   push_data,
  output logic                    full,
  output logic                    empty,
  input  logic                    commit_valid,
  input  logic [ROB_ID_WIDTH-1:0] commit_rob_id,
  input  logic                    flush,
  input  logic [ADDR_WIDTH-1:0]   ld_addr,
  input  logic [SIZE_WIDTH-1:0]   ld_size,
  output logic [DATA_WIDTH-1:0]   fwd_data,
  output logic [DATA_WIDTH/8-1:0] fwd_mask,
  output logic                    bus_req,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_data,
  output logic [DATA_WIDTH/8-1:0] bus_wmask,
  input  logic                    bus_ready
);
  localparam int LANES  = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(LANES);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam int LINE_W = ADDR_WIDTH - OFF_W;

  // Pointers carry one wrap bit above the index so full and empty are distinguishable.
  logic [PTR_W-1:0] head, tail, count, n_cmt;
  logic [IDX_W-1:0] head_idx, tail_idx, scan_idx;

  logic [DEPTH-1:0]        ent_vld, ent_cmt, cmt_hit;
  logic [ROB_ID_WIDTH-1:0] ent_rob  [DEPTH];
  logic [LINE_W-1:0]       ent_line [DEPTH];
  logic [LANES-1:0]        ent_mask [DEPTH];
  logic [DATA_WIDTH-1:0]   ent_data [DEPTH];

  logic             push_ok, pop;
  logic [OFF_W-1:0] push_off;
  logic [LANES-1:0] push_mask, ld_mask;

  // Byte-enable mask for an access of 2**sz bytes at lane offset off; lanes past the line are dropped.
  function automatic logic [LANES-1:0] size_mask(input logic [SIZE_WIDTH-1:0] sz,
                                                 input logic [OFF_W-1:0] off);
    logic [2*LANES-1:0] m;
    m = '0;
    for (int b = 0; b < LANES; b++) begin
      if (b < (1 << sz)) m[b] = 1'b1;
    end
    m = m << off;
    return m[LANES-1:0];
  endfunction

  assign head_idx  = head[IDX_W-1:0];
  assign tail_idx  = tail[IDX_W-1:0];
  assign count     = tail - head;
  assign full      = (count == PTR_W'(DEPTH));
  assign empty     = (count == '0);

  assign push_off  = push_addr[OFF_W-1:0];
  assign push_mask = size_mask(push_size, push_off);
  assign ld_mask   = size_mask(ld_size, ld_addr[OFF_W-1:0]);

  assign push_ok   = push && !full && !flush;
  assign bus_req   = !empty && ent_cmt[head_idx];
  assign pop       = bus_req && bus_ready;

  // Head fields are gated by its valid bit so the bus side reads as zero when nothing is held.
  assign bus_addr  = ent_vld[head_idx] ? {ent_line[head_idx], {OFF_W{1'b0}}} : '0;
  assign bus_data  = ent_vld[head_idx] ? ent_data[head_idx] : '0;
  assign bus_wmask = ent_vld[head_idx] ? ent_mask[head_idx] : '0;

  // Commit match and surviving-entry count use pre-edge contents only.
  always_comb begin
    cmt_hit = '0;
    n_cmt   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cmt_hit[i] = commit_valid && ent_vld[i] && !ent_cmt[i] && (ent_rob[i] == commit_rob_id);
      if (ent_vld[i] && (ent_cmt[i] || cmt_hit[i])) n_cmt = n_cmt + PTR_W'(1);
    end
  end

  // Oldest-to-youngest scan so the youngest matching writer overrides each byte.
  always_comb begin
    fwd_mask = '0;
    fwd_data = '0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_idx + IDX_W'(k);
      if (ent_vld[scan_idx] && (ent_line[scan_idx] == ld_addr[ADDR_WIDTH-1:OFF_W])) begin
        for (int b = 0; b < LANES; b++) begin
          if (ent_mask[scan_idx][b] && ld_mask[b]) begin
            fwd_mask[b]         = 1'b1;
            fwd_data[8*b +: 8]  = ent_data[scan_idx][8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      ent_vld <= '0;
      ent_cmt <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cmt_hit[i]) ent_cmt[i] <= 1'b1;
      end
      if (flush) begin
        // Committed entries are a prefix from head, so they survive as head..head+n_cmt-1.
        tail <= head + n_cmt;
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_vld[i] && !ent_cmt[i] && !cmt_hit[i]) ent_vld[i] <= 1'b0;
        end
      end else if (push_ok) begin
        ent_vld[tail_idx] <= 1'b1;
        ent_cmt[tail_idx] <= 1'b0;
        tail              <= tail + PTR_W'(1);
      end
      if (pop) begin
        ent_vld[head_idx] <= 1'b0;
        ent_cmt[head_idx] <= 1'b0;
        head              <= head + PTR_W'(1);
      end
    end
  end

  // Payload needs no reset; it is only observed through valid entries.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      ent_rob[tail_idx]  <= push_rob_id;
      ent_line[tail_idx] <= push_addr[ADDR_WIDTH-1:OFF_W];
      ent_mask[tail_idx] <= push_mask;
      ent_data[tail_idx] <= push_data << {push_off, 3'b000};
    end
  end

endmodule

// File: tb/tb_lsu_store_buffer.sv
module tb_lsu_store_buffer;
  localparam int DEPTH = 4;

  logic        clk, rst;
  logic        push, commit_valid, flush, bus_ready;
  logic [6:0]  push_rob_id, commit_rob_id;
  logic [31:0] push_addr, push_data, ld_addr;
  logic [1:0]  push_size, ld_size;
  logic        full, empty, bus_req;
  logic [31:0] fwd_data, bus_addr, bus_data;
  logic [3:0]  fwd_mask, bus_wmask;

  lsu_store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                     .ROB_ID_WIDTH(7), .SIZE_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .push(push), .push_rob_id(push_rob_id),
    .push_addr(push_addr), .push_size(push_size), .push_data(push_data),
    .full(full), .empty(empty), .commit_valid(commit_valid),
    .commit_rob_id(commit_rob_id), .flush(flush), .ld_addr(ld_addr),
    .ld_size(ld_size), .fwd_data(fwd_data), .fwd_mask(fwd_mask),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_data(bus_data),
    .bus_wmask(bus_wmask), .bus_ready(bus_ready));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [6:0]  rob;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
    logic        cmt;
  } st_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wm;
  } bus_t;

  st_t  mq[$];      // reference model: buffer contents, oldest first
  bus_t exp_q[$];   // scoreboard: committed writes in expected drain order

  int checks = 0, errors = 0;
  int pred_drains = 0, mon_total = 0;
  bit model_ok = 1'b0;
  logic [6:0] next_rob = 7'd60;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // True when an access of 2**sz bytes at a touches byte address x within a's own line.
  function automatic bit covers(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] x);
    longint unsigned lo, hi, xx;
    lo = a;
    hi = lo + (64'd1 << sz);
    xx = x;
    return (xx >= lo) && (xx < hi) && (x[31:2] == a[31:2]);
  endfunction

  function automatic bus_t bus_of(input st_t e);
    bus_t r;
    r.addr = {e.addr[31:2], 2'b00};
    r.data = e.data << (8 * e.addr[1:0]);
    for (int b = 0; b < 4; b++) r.wm[b] = covers(e.addr, e.size, r.addr + 32'(b));
    return r;
  endfunction

  task automatic model_fwd(output logic [3:0] m, output logic [31:0] d);
    logic [31:0] x;
    st_t e;
    m = '0;
    d = '0;
    for (int b = 0; b < 4; b++) begin
      x = {ld_addr[31:2], 2'b00} + 32'(b);
      if (covers(ld_addr, ld_size, x)) begin
        foreach (mq[i]) begin
          e = mq[i];
          if (covers(e.addr, e.size, x)) begin
            m[b] = 1'b1;
            d[8*b +: 8] = 8'(e.data >> (8 * (x - e.addr)));
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0]  m;
    logic [31:0] d;
    model_fwd(m, d);
    chk("empty",    empty,    64'(mq.size() == 0));
    chk("full",     full,     64'(mq.size() == DEPTH));
    chk("bus_req",  bus_req,  64'(mq.size() > 0 && mq[0].cmt));
    chk("fwd_mask", fwd_mask, m);
    chk("fwd_data", fwd_data, d);
  endtask

  task automatic model_update();
    bit   full_pre, do_pop;
    st_t  e;
    st_t  nq[$];
    if (!rst) begin
      mq.delete();
      exp_q.delete();
      model_ok = 1'b1;
      return;
    end
    if (!model_ok) return;
    full_pre = (mq.size() == DEPTH);
    do_pop   = (mq.size() > 0) && mq[0].cmt && bus_ready;
    if (commit_valid) begin
      foreach (mq[i]) begin
        e = mq[i];
        if (e.rob == commit_rob_id && !e.cmt) begin
          e.cmt = 1'b1;
          mq[i] = e;
          exp_q.push_back(bus_of(e));
        end
      end
    end
    if (flush) begin
      foreach (mq[i]) if (mq[i].cmt) nq.push_back(mq[i]);
      mq = nq;
    end else if (push && !full_pre) begin
      e.rob = push_rob_id; e.addr = push_addr; e.size = push_size;
      e.data = push_data;  e.cmt = 1'b0;
      mq.push_back(e);
    end
    if (do_pop) begin
      void'(mq.pop_front());
      pred_drains++;
    end
  endtask

  // Entered and left at posedge+1 with inputs already driven.
  task automatic step();
    #1;
    if (model_ok) check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    push = 0; push_rob_id = 0; push_addr = 0; push_size = 0; push_data = 0;
    commit_valid = 0; commit_rob_id = 0; flush = 0; bus_ready = 0;
    ld_addr = 0; ld_size = 0;
  endtask

  task automatic do_push(input logic [6:0] rob, input logic [31:0] a,
                         input logic [1:0] sz, input logic [31:0] d);
    push = 1; push_rob_id = rob; push_addr = a; push_size = sz; push_data = d;
  endtask

  task automatic drain_all();
    int n;
    bit found;
    n = 0;
    while (mq.size() > 0 && n < 40) begin
      idle();
      bus_ready = 1;
      found = 0;
      foreach (mq[i]) if (!found && !mq[i].cmt) begin
        found = 1; commit_valid = 1; commit_rob_id = mq[i].rob;
      end
      step();
      n++;
    end
    if (mq.size() != 0) chk("drain_timeout", empty, 1);
  endtask

  // Monitor: every handshake the DUT presents is matched against the scoreboard.
  initial begin
    bus_t t;
    forever begin
      @(negedge clk);
      if (model_ok && rst === 1'b1 && bus_req === 1'b1 && bus_ready === 1'b1) begin
        mon_total++;
        if (exp_q.size() == 0) chk("drain_unexpected", bus_req, 0);
        else begin
          t = exp_q.pop_front();
          chk("bus_addr",  bus_addr,  t.addr);
          chk("bus_data",  bus_data,  t.data);
          chk("bus_wmask", bus_wmask, t.wm);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst = 0;
    @(posedge clk); #1;
    step();
    step();
    chk("reset_bus_wmask", bus_wmask, 0);
    rst = 1;

    // Misaligned halfword: upper byte falls off the line.
    idle(); do_push(7'd7, 32'haaccbeef, 2'd1, 32'hdeadbeef); step();
    idle(); #1;
    chk("t1_empty", empty, 0);
    chk("t1_req_precommit", bus_req, 0);
    commit_valid = 1; commit_rob_id = 7'd7; step();
    idle(); #1;
    chk("t1_req", bus_req, 1);
    chk("t1_addr", bus_addr, 32'haaccbeec);
    chk("t1_wmask", bus_wmask, 4'b1000);
    chk("t1_byte3", bus_data[31:24], 8'hef);
    bus_ready = 1; step();
    idle(); #1;
    chk("t1_empty_after", empty, 1);
    step();

    // Fill past capacity, then drain and push in the same cycle.
    for (int i = 0; i < DEPTH + 1; i++) begin
      idle(); do_push(7'(10 + i), 32'h300 + 32'(4 * i), 2'd2, $urandom); step();
    end
    idle(); #1;
    chk("t2_full", full, 1);
    commit_valid = 1; commit_rob_id = 7'd10; step();
    idle(); do_push(7'd30, 32'h400, 2'd2, 32'h12345678); bus_ready = 1; step();
    idle(); ld_addr = 32'h400; ld_size = 2'd2; #1;
    chk("t2_full_after_pop", full, 0);
    chk("t2_refused_fwd", fwd_mask, 0);
    flush = 1; step();

    // Flush keeps only the committed prefix.
    idle(); do_push(7'd1, 32'h500, 2'd2, 32'h01010101); step();
    idle(); do_push(7'd2, 32'h504, 2'd2, 32'h02020202); step();
    idle(); do_push(7'd3, 32'h508, 2'd2, 32'h03030303); step();
    idle(); commit_valid = 1; commit_rob_id = 7'd1; step();
    idle(); flush = 1; step();
    idle(); ld_addr = 32'h504; ld_size = 2'd2; #1;
    chk("t3_flushed_fwd", fwd_mask, 0);
    ld_addr = 32'h500; #1;
    chk("t3_kept_fwd", fwd_mask, 4'b1111);
    do_push(7'd4, 32'h50c, 2'd2, 32'h04040404); step();
    drain_all();

    // Youngest writer wins per byte.
    idle(); do_push(7'd40, 32'h100, 2'd2, 32'h11223344); step();
    idle(); do_push(7'd41, 32'h101, 2'd0, 32'h000000aa); step();
    idle(); ld_addr = 32'h100; ld_size = 2'd2; #1;
    chk("t4_mask", fwd_mask, 4'b1111);
    chk("t4_data", fwd_data, 32'h1122aa44);
    step();
    idle(); flush = 1; step();

    // Partial coverage.
    idle(); do_push(7'd42, 32'h202, 2'd1, 32'h0000beef); step();
    idle(); ld_addr = 32'h200; ld_size = 2'd2; #1;
    chk("t5_mask", fwd_mask, 4'b1100);
    chk("t5_data", fwd_data, 32'hbeef0000);
    step();
    idle(); flush = 1; step();

    // A store pushed in its own commit cycle stays uncommitted.
    idle(); do_push(7'd50, 32'h600, 2'd2, 32'h5); commit_valid = 1; commit_rob_id = 7'd50; step();
    idle(); #1;
    chk("t6_no_commit", bus_req, 0);
    flush = 1; step();

    // Randomized mix with occasional mid-run resets.
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit found;
      idle();
      rst = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 9) < 6) begin
        do_push(next_rob, 32'h100 + 32'($urandom_range(0, 11)), 2'($urandom_range(0, 3)), $urandom);
        next_rob = next_rob + 7'd1;
      end
      if ($urandom_range(0, 1) == 1) begin
        found = 0;
        foreach (mq[i]) if (!found && !mq[i].cmt) begin
          found = 1; commit_valid = 1; commit_rob_id = mq[i].rob;
        end
      end
      flush     = ($urandom_range(0, 19) == 0);
      bus_ready = ($urandom_range(0, 9) < 6);
      ld_addr   = 32'h100 + 32'($urandom_range(0, 11));
      ld_size   = 2'($urandom_range(0, 2));
      step();
    end
    rst = 1;
    drain_all();
    idle(); step(); step();
    chk("drain_count", mon_total, pred_drains);
    chk("scoreboard_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
